imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined RISC-V immediate generator; successor to the single-cycle 5-bit immediate slice.
- Decodes I/S/B/J/U immediates from a full 32-bit instruction and sign-extends them to XLEN.
- Registered over STAGES pipeline stages with a valid/ready handshake and back-pressure.
- Sits between the decode stage and the operand-select muxes of the pipelined core.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- STAGES, 1, number of register stages, 1..3; equals latency in cycles.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  instruction/select pair valid.
- in_ready_o  out  1  block can accept the input this cycle.
- inst_i  in  32  instruction word.
- immsel_i  in  SEL_W  one-hot format select. SEL_W is 5, or 6 with IMMGEN_ZIMM_EN.
- out_valid_o  out  1  immediate valid.
- out_ready_i  in  1  consumer accepts the output.
- imm_o  out  XLEN  sign-extended immediate.
- err_o  out  1  the select was not one-hot; qualified by out_valid_o.

Behaviour:
- Reset (async assert, sync release):
  - All stage valids are 0.
  - imm_o = 0, err_o = 0, out_valid_o = 0.
  - in_ready_o = 1 on the first cycle after release.
- immsel encodings:
  - I = 5'b00001: sext(inst[31:20]).
  - S = 5'b00010: sext({inst[31:25], inst[11:7]}).
  - B = 5'b00100: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - J = 5'b01000: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - U = 5'b10000: sext({inst[31:12], 12'b0}). For XLEN=64, bits 63:32 replicate inst[31].
- Non-one-hot select (including all-zero):
  - imm = 0, err = 1.
  - The transaction still flows through the pipe; it is never dropped.
- Decode is combinational at the input. The result is captured into stage 0 on the handshake (in_valid_i & in_ready_o).
- Stage k register:
  - Loads from stage k-1 when stage k is empty or its contents advance this cycle.
  - Holds otherwise.
- in_ready_o = !stage0_valid | stage0_advance (fully combinational ready chain; no bubbles).
- Throughput: one transaction per cycle when out_ready_i = 1.
- Latency: exactly STAGES cycles from input handshake to out_valid_o.
- Back-pressure:
  - While out_valid_o = 1 and out_ready_i = 0, imm_o and err_o hold stable.
  - Upstream stages fill, then in_ready_o drops.
  - At most STAGES transactions are in flight.
- Output pop and input push in the same cycle with the pipe full: both occur, occupancy is unchanged, and ordering is preserved.
- Output data registers load only when the stage's valid is written to 1. Data is don't-care while valid = 0, but the reset value is 0.
- rst_ni asserted mid-stream: all in-flight transactions are discarded immediately and outputs return to reset values asynchronously.
- No combinational path from inst_i/immsel_i to imm_o, even when STAGES=1.

Optional Feature:
- Macro: IMMGEN_ZIMM_EN.
- Defined:
  - SEL_W = 6, with an added encoding Z = 6'b100000.
  - Z output is the zero-extended CSR immediate {XLEN-5 zeros, inst[19:15]}.
  - I/S/B/J/U encodings are zero-extended to 6 bits.
- Undefined:
  - SEL_W = 5; Z does not exist.
  - No zimm logic is synthesised.

Test Plan:
- I-type: inst=0xFFF00093, sel=I, XLEN=32, STAGES=1 -> after 1 cycle out_valid=1, imm=0xFFFFFFFF, err=0.
- S/B/U/J back-to-back:
  - Stimulus, one per cycle: 0xFE112E23/S, 0xFE000CE3/B, 0x123450B7/U, 0x010000EF/J, STAGES=2, out_ready=1.
  - Response, in order on consecutive cycles starting at cycle 2: 0xFFFFFFFC, 0xFFFFFFF8, 0x12345000, 0x00000010.
- Back-pressure, STAGES=3:
  - Hold out_ready=0 and push 4 transactions -> in_ready drops after 3 accepted; imm_o stable.
  - Release out_ready -> all 3 drain in order, then the 4th is accepted.
- Illegal select: sel=5'b00011 and sel=5'b00000 -> imm=0, err=1, still delivered in order between legal transactions.
- XLEN=64, U-type with inst=0x800000B7 -> imm=0xFFFFFFFF80000000.
- Reset mid-stream: assert rst_ni low with 2 transactions in flight -> out_valid=0 and imm=0 immediately, nothing emitted after release. With IMMGEN_ZIMM_EN, inst=0x000FD073 and sel=Z -> imm=0x0000001F.

Source files
------------

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Pipelined RISC-V immediate generator (I/S/B/J/U, optional Z
//               CSR immediate when IMMGEN_ZIMM_EN is defined), STAGES-deep
//               valid/ready pipe with back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
`ifdef IMMGEN_ZIMM_EN
    input  logic [5:0]      immsel_i,
`else
    input  logic [4:0]      immsel_i,
`endif
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic            err_o
);

`ifdef IMMGEN_ZIMM_EN
    localparam int c_SEL_W = 6;
`else
    localparam int c_SEL_W = 5;
`endif

    localparam logic [c_SEL_W-1:0] c_SEL_I = c_SEL_W'(5'b00001);
    localparam logic [c_SEL_W-1:0] c_SEL_S = c_SEL_W'(5'b00010);
    localparam logic [c_SEL_W-1:0] c_SEL_B = c_SEL_W'(5'b00100);
    localparam logic [c_SEL_W-1:0] c_SEL_J = c_SEL_W'(5'b01000);
    localparam logic [c_SEL_W-1:0] c_SEL_U = c_SEL_W'(5'b10000);
`ifdef IMMGEN_ZIMM_EN
    localparam logic [c_SEL_W-1:0] c_SEL_Z = 6'b100000;
`endif

    // ------------------------------------------------------------------
    // Input-side decode (combinational, captured only into stage 0)
    // ------------------------------------------------------------------
    logic [31:0]      w_raw;
    logic [XLEN-1:0]  w_dec_imm;
    logic             w_dec_err;
    logic             w_unused;

    assign w_unused = ^inst_i[6:0];

    always_comb begin
        w_raw     = '0;
        w_dec_err = 1'b0;
        case (immsel_i)
            c_SEL_I: w_raw = {{20{inst_i[31]}}, inst_i[31:20]};
            c_SEL_S: w_raw = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            c_SEL_B: w_raw = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            c_SEL_J: w_raw = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            c_SEL_U: w_raw = {inst_i[31:12], 12'b0};
`ifdef IMMGEN_ZIMM_EN
            c_SEL_Z: w_raw = '0;
`endif
            default: w_dec_err = 1'b1;
        endcase
        w_dec_imm = XLEN'($signed(w_raw));
`ifdef IMMGEN_ZIMM_EN
        // The CSR immediate is the only zero-extended format
        if (immsel_i == c_SEL_Z) begin
            w_dec_imm = XLEN'(inst_i[19:15]);
        end
`endif
    end

    // ------------------------------------------------------------------
    // Ready chain: stage k may load when empty or when it drains this cycle
    // ------------------------------------------------------------------
    logic [STAGES-1:0] w_vld;
    logic [STAGES-1:0] w_rdy;
    logic [XLEN-1:0]   w_stg_imm [STAGES];
    logic [STAGES-1:0] w_stg_err;
    logic              w_chain;

    always_comb begin
        w_chain = out_ready_i;
        w_rdy   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_chain  = !w_vld[k] | w_chain;
            w_rdy[k] = w_chain;
        end
    end

    // ------------------------------------------------------------------
    // Register stages
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic            w_src_v;
        logic [XLEN-1:0] w_src_imm;
        logic            w_src_err;
        logic            r_v;
        logic [XLEN-1:0] r_imm;
        logic            r_err;

        if (k == 0) begin : g_head
            assign w_src_v   = in_valid_i;
            assign w_src_imm = w_dec_imm;
            assign w_src_err = w_dec_err;
        end else begin : g_body
            assign w_src_v   = w_vld[k-1];
            assign w_src_imm = w_stg_imm[k-1];
            assign w_src_err = w_stg_err[k-1];
        end

        // Data registers only update when a valid entry is written
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_v   <= 1'b0;
                r_imm <= '0;
                r_err <= 1'b0;
            end else if (w_rdy[k]) begin
                r_v <= w_src_v;
                if (w_src_v) begin
                    r_imm <= w_src_imm;
                    r_err <= w_src_err;
                end
            end
        end

        assign w_vld[k]     = r_v;
        assign w_stg_imm[k] = r_imm;
        assign w_stg_err[k] = r_err;
    end

    assign in_ready_o  = w_rdy[0];
    assign out_valid_o = w_vld[STAGES-1];
    assign imm_o       = w_stg_imm[STAGES-1];
    assign err_o       = w_stg_err[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Scoreboard bench for imm_gen_pipe across three configurations
//               (XLEN/STAGES = 32/1, 32/2, 64/3); Z test under IMMGEN_ZIMM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

`ifdef IMMGEN_ZIMM_EN
    localparam int c_SEL_W = 6;
`else
    localparam int c_SEL_W = 5;
`endif

    typedef struct {
        logic [63:0] imm;
        logic        err;
        int          t;
        bit          lat;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               tb_valid;
    logic [31:0]        tb_inst;
    logic [c_SEL_W-1:0] tb_sel;
    logic               tb_oready;
    logic [1:0]         dsel;

    logic [2:0]  rdy;
    logic [2:0]  ov;
    logic [2:0]  err;
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic [63:0] imm3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(tb_valid && dsel == 2'd0), .in_ready_o(rdy[0]),
        .inst_i(tb_inst), .immsel_i(tb_sel),
        .out_valid_o(ov[0]), .out_ready_i(tb_oready),
        .imm_o(imm1), .err_o(err[0])
    );

    imm_gen_pipe #(.XLEN(32), .STAGES(2)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(tb_valid && dsel == 2'd1), .in_ready_o(rdy[1]),
        .inst_i(tb_inst), .immsel_i(tb_sel),
        .out_valid_o(ov[1]), .out_ready_i(tb_oready),
        .imm_o(imm2), .err_o(err[1])
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(3)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(tb_valid && dsel == 2'd2), .in_ready_o(rdy[2]),
        .inst_i(tb_inst), .immsel_i(tb_sel),
        .out_valid_o(ov[2]), .out_ready_i(tb_oready),
        .imm_o(imm3), .err_o(err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] imm, input logic e,
                           input int stages, input exp_t x);
        check({tag, "_imm"}, imm, x.imm);
        check({tag, "_err"}, 64'(e), 64'(x.err));
        if (x.lat) check({tag, "_lat"}, 64'(cyc - x.t), 64'(stages));
    endtask

    // Output monitors: pop in-order expectations on every output handshake
    always @(negedge clk) begin
        if (rst_n && ov[0] && tb_oready) begin
            check("d0_expected", 64'(q0.size() > 0), 64'd1);
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk_out("d0", 64'(imm1), err[0], 1, e0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov[1] && tb_oready) begin
            check("d1_expected", 64'(q1.size() > 0), 64'd1);
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk_out("d1", 64'(imm2), err[1], 2, e1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov[2] && tb_oready) begin
            check("d2_expected", 64'(q2.size() > 0), 64'd1);
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                chk_out("d2", imm3, err[2], 3, e2);
            end
        end
    end

    // Called just after a rising edge; returns just after the capturing edge
    task automatic push(input logic [31:0] inst, input logic [c_SEL_W-1:0] sel,
                        input logic [63:0] eimm, input logic eerr, input bit lat);
        exp_t x;
        bit   done;
        int   n;
        done     = 1'b0;
        n        = 0;
        tb_inst  = inst;
        tb_sel   = sel;
        tb_valid = 1'b1;
        while (!done && n < 50) begin
            @(negedge clk);
            if (rdy[dsel]) begin
                x.imm = eimm; x.err = eerr; x.t = cyc; x.lat = lat;
                case (dsel)
                    2'd0:    q0.push_back(x);
                    2'd1:    q1.push_back(x);
                    default: q2.push_back(x);
                endcase
                done = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        tb_valid = 1'b0;
        check("push_accepted", 64'(done), 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        tb_valid  = 1'b0;
        tb_inst   = '0;
        tb_sel    = '0;
        tb_oready = 1'b1;
        dsel      = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_ov",   64'(ov),   64'd0);
        check("rst_err",  64'(err),  64'd0);
        check("rst_rdy",  64'(rdy),  64'd7);
        check("rst_imm1", 64'(imm1), 64'd0);
        check("rst_imm2", 64'(imm2), 64'd0);
        check("rst_imm3", imm3,      64'd0);
        @(posedge clk); #1;

        // I-type, single stage: output right after the capturing edge
        dsel = 2'd0;
        push(32'hFFF00093, 5'b00001, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
        check("i1_ov",  64'(ov[0]), 64'd1);
        check("i1_imm", 64'(imm1),  64'h0000_0000_FFFF_FFFF);
        wait_drain();

        // S/B/U/J back-to-back on two stages
        dsel = 2'd1;
        push(32'hFE112E23, 5'b00010, 64'h0000_0000_FFFF_FFFC, 1'b0, 1'b1);
        push(32'hFE000CE3, 5'b00100, 64'h0000_0000_FFFF_FFF8, 1'b0, 1'b1);
        push(32'h123450B7, 5'b10000, 64'h0000_0000_1234_5000, 1'b0, 1'b1);
        push(32'h010000EF, 5'b01000, 64'h0000_0000_0000_0010, 1'b0, 1'b1);
        wait_drain();

        // Illegal selects delivered in order between legal ones
        push(32'hFFF00093, 5'b00001, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
        push(32'hFFFFFFFF, 5'b00011, 64'h0,                   1'b1, 1'b1);
        push(32'hFFFFFFFF, 5'b00000, 64'h0,                   1'b1, 1'b1);
        push(32'h123450B7, 5'b10000, 64'h0000_0000_1234_5000, 1'b0, 1'b1);
        wait_drain();

        // Back-pressure on three stages, XLEN=64
        dsel      = 2'd2;
        tb_oready = 1'b0;
        push(32'hFFF00093, 5'b00001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        push(32'hFE112E23, 5'b00010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        push(32'h800000B7, 5'b10000, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
        tb_inst  = 32'h010000EF;
        tb_sel   = 5'b01000;
        tb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rdy", 64'(rdy[2]), 64'd0);
            check("bp_ov",  64'(ov[2]),  64'd1);
            check("bp_imm", imm3,        64'hFFFF_FFFF_FFFF_FFFF);
            @(posedge clk); #1;
        end
        tb_oready = 1'b1;
        push(32'h010000EF, 5'b01000, 64'h0000_0000_0000_0010, 1'b0, 1'b0);
        wait_drain();

        // Reset with two transactions in flight
        dsel = 2'd1;
        push(32'hFE112E23, 5'b00010, 64'h0000_0000_FFFF_FFFC, 1'b0, 1'b1);
        push(32'h123450B7, 5'b10000, 64'h0000_0000_1234_5000, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mrst_ov",  64'(ov[1]),  64'd0);
        check("mrst_imm", 64'(imm2),   64'd0);
        check("mrst_err", 64'(err[1]), 64'd0);
        q1.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mrst_quiet", 64'(ov[1]), 64'd0);
            @(posedge clk); #1;
        end
        check("mrst_rdy", 64'(rdy[1]), 64'd1);

`ifdef IMMGEN_ZIMM_EN
        dsel = 2'd0;
        push(32'h000FD073, 6'b100000, 64'h0000_0000_0000_001F, 1'b0, 1'b1);
        wait_drain();
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
